// File: rtl/coproc_sequencer_if.sv
// Handshake bundle between the command sequencer, the UART demux, the ALU and UART TX.
interface coproc_sequencer_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;

  logic              i_cmd_done;
  logic [DATA_W-1:0] i_num_1;
  logic [DATA_W-1:0] i_num_2;
  logic [DATA_W-1:0] i_opcode;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [DATA_W-1:0] o_alu_op;
  logic              o_alu_start;
  logic              i_alu_done;
  logic [RES_W-1:0]  i_alu_result;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_start;
  logic              i_tx_busy;
  logic              o_busy;
  logic [DATA_W-1:0] o_drop_count;

  // Sequencer side
  modport slave (
    input  i_cmd_done, i_num_1, i_num_2, i_opcode, i_alu_done, i_alu_result, i_tx_busy,
    output o_alu_a, o_alu_b, o_alu_op, o_alu_start, o_tx_data, o_tx_start, o_busy,
           o_drop_count
  );

  // Environment side (demux, ALU, UART TX)
  modport master (
    output i_cmd_done, i_num_1, i_num_2, i_opcode, i_alu_done, i_alu_result, i_tx_busy,
    input  o_alu_a, o_alu_b, o_alu_op, o_alu_start, o_tx_data, o_tx_start, o_busy,
           o_drop_count
  );
endinterface

// File: rtl/coproc_sequencer.sv
// Co-processor command sequencer: validates a command, runs the ALU with a timeout,
// then streams a status/result-high/result-low frame to UART TX.
module coproc_sequencer #(
  parameter logic [7:0]  MAX_OPCODE     = 8'd15,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic               i_clk,
  input  logic               reset,
  coproc_sequencer_if.slave  bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT_ALU = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_WAIT_TX  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              prev_done_q, prev_done_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] alu_op_q, alu_op_d;
  logic              alu_start_q, alu_start_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] drop_q, drop_d;
  logic              cmd_edge;
  logic [DATA_W-1:0] cur_byte;

  assign cmd_edge = bus.i_cmd_done & ~prev_done_q;

  // Select the frame byte for the current index
  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = status_q;
      2'd1:    cur_byte = result_q[15:8];
      default: cur_byte = result_q[7:0];
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    prev_done_d = bus.i_cmd_done;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    status_d    = status_q;
    result_d    = result_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    drop_d      = drop_q;

    // Any edge outside IDLE is discarded but counted, saturating
    if (cmd_edge && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_edge) begin
          alu_a_d  = bus.i_num_1;
          alu_b_d  = bus.i_num_2;
          alu_op_d = bus.i_opcode;
          idx_d    = 2'd0;
          if (bus.i_opcode <= MAX_OPCODE) begin
            state_d = S_LAUNCH;
          end else begin
            status_d = 8'h02;
            result_d = 16'h0000;
            state_d  = S_SEND;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.i_alu_done) begin
          result_d = bus.i_alu_result;
          status_d = 8'h00;
          state_d  = S_SEND;
        end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          result_d = 16'h0000;
          status_d = 8'h01;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.i_tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (bus.i_tx_busy) state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (!bus.i_tx_busy) begin
          if (idx_q == 2'd2) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Start pulse is registered so it is high exactly during the LAUNCH cycle
    alu_start_d = (state_d == S_LAUNCH);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      prev_done_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      status_q    <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      prev_done_q <= prev_done_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      status_q    <= status_d;
      result_q    <= result_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.o_alu_a      = alu_a_q;
  assign bus.o_alu_b      = alu_b_q;
  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_alu_start  = alu_start_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_drop_count = drop_q;
endmodule

// File: tb/tb_coproc_sequencer.sv
// Bench for coproc_sequencer: directed scenarios plus random commands against a frame model.
module tb_coproc_sequencer;
  localparam logic [15:0] TMO    = 16'd8;
  localparam logic [7:0]  MAX_OP = 8'd15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coproc_sequencer_if bus();

  coproc_sequencer #(.MAX_OPCODE(MAX_OP), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] cap[$];
  int         ph = 0, wait_n = 0, len = 0;
  logic [7:0] cur = 8'h00;
  int         tx_viol = 0;
  int         alu_starts = 0, alu_viol = 0;
  logic       prev_start = 1'b0;
  bit         hold_busy = 1'b0;
  int         hold_left = 0;
  logic [7:0] drop_exp = 8'h00;

  // Counts ALU launches and flags any launch wider than one cycle
  always @(negedge clk) begin
    if (bus.o_alu_start === 1'b1) begin
      alu_starts++;
      if (prev_start) alu_viol++;
    end
    prev_start = (bus.o_alu_start === 1'b1);
  end

  // UART TX responder: captures bytes, optional ack delay, then busy for a few cycles
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      ph = 0;
      bus.i_tx_busy = 1'b0;
    end else begin
      case (ph)
        0: if (bus.o_tx_start === 1'b1) begin
          cap.push_back(bus.o_tx_data);
          cur = bus.o_tx_data;
          wait_n = $urandom_range(0, 2);
          if (wait_n == 0) begin
            bus.i_tx_busy = 1'b1; len = $urandom_range(2, 4); ph = 2;
          end else ph = 1;
        end
        1: begin
          if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== cur) tx_viol++;
          wait_n--;
          if (wait_n == 0) begin
            bus.i_tx_busy = 1'b1; len = $urandom_range(2, 4); ph = 2;
          end
        end
        default: begin
          if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== cur) tx_viol++;
          if (!hold_busy) begin
            len--;
            if (len <= 0) begin
              bus.i_tx_busy = 1'b0; ph = 0;
            end
          end
        end
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and release a held cmd_done when its time is up
  task automatic tick();
    @(negedge clk);
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) bus.i_cmd_done = 1'b0;
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  // Expected frame: invalid opcode -> 02; ALU answers within the timeout -> 00+result; else 01
  function automatic logic [23:0] model_frame(input logic [7:0] op, input int d, input logic [15:0] res);
    if (op > MAX_OP) return {8'h02, 16'h0000};
    if (d >= 1 && d <= int'(TMO)) return {8'h00, res};
    return {8'h01, 16'h0000};
  endfunction

  // d: ALU done arrives d cycles after the start pulse (0 = never)
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int d, input logic [15:0] res, input int hold, input int extra);
    logic [23:0] exp_f;
    logic        exp_start;
    logic [7:0]  got;
    int          s0, base, tv0, av0, budget, ex;
    exp_f = model_frame(op, d, res);
    exp_start = (op <= MAX_OP);
    s0 = alu_starts; base = cap.size(); tv0 = tx_viol; av0 = alu_viol; ex = extra;
    tick();
    bus.i_num_1 = a; bus.i_num_2 = b; bus.i_opcode = op;
    bus.i_cmd_done = 1'b1; hold_left = hold;
    tick();
    check("alu_start_latency", 32'(bus.o_alu_start), 32'(exp_start));
    check("busy_after_cmd", 32'(bus.o_busy), 32'd1);
    if (d > 0) begin
      repeat (d) tick();
      bus.i_alu_done = 1'b1; bus.i_alu_result = res;
      tick();
      bus.i_alu_done = 1'b0; bus.i_alu_result = 16'($urandom);
    end
    budget = 0;
    while (!(cap.size() == base + 3 && bus.o_busy === 1'b0 && ex == 0 && hold_left == 0)
           && budget < 400) begin
      tick();
      budget++;
      if (ex > 0 && hold_left == 0 && bus.i_cmd_done == 1'b0 && bus.o_busy === 1'b1 &&
          cap.size() > base && budget % 2 == 0) begin
        bus.i_cmd_done = 1'b1; hold_left = 1; ex--;
        drop_exp = sat_inc(drop_exp);
      end
    end
    check("frame_in_time", 32'(budget < 400), 32'd1);
    check("frame_len", 32'(cap.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (cap.size() > base + i) ? cap[base + i] : 8'hxx;
      check($sformatf("tx_byte%0d", i), 32'(got), 32'(exp_f[23 - 8*i -: 8]));
    end
    check("alu_a", 32'(bus.o_alu_a), 32'(a));
    check("alu_b", 32'(bus.o_alu_b), 32'(b));
    check("alu_op", 32'(bus.o_alu_op), 32'(op));
    check("alu_start_count", 32'(alu_starts - s0), 32'(exp_start));
    check("alu_start_width", 32'(alu_viol - av0), 32'd0);
    check("tx_start_data_stable", 32'(tx_viol - tv0), 32'd0);
    check("drop_count", 32'(bus.o_drop_count), 32'(drop_exp));
    check("extra_edges_sent", 32'(ex), 32'd0);
    check("idle_after_frame", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int base, budget, s0;
    logic [7:0] got;
    bus.i_cmd_done = 1'b0; bus.i_num_1 = '0; bus.i_num_2 = '0; bus.i_opcode = '0;
    bus.i_alu_done = 1'b0; bus.i_alu_result = '0;
    repeat (3) tick();
    #1;
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_alu_start", 32'(bus.o_alu_start), 32'd0);
    check("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_drop", 32'(bus.o_drop_count), 32'd0);
    check("rst_alu_a", 32'(bus.o_alu_a), 32'd0);
    rst_n = 1'b1;

    // Normal, invalid opcode, timeout boundaries
    run_cmd(8'h12, 8'h34, 8'd3,   4, 16'h0446, 1, 0);
    run_cmd(8'h55, 8'h66, 8'h20,  3, 16'h1234, 1, 0);
    run_cmd(8'h01, 8'h02, 8'd5,   0, 16'hABCD, 1, 0);
    run_cmd(8'h0A, 8'h0B, 8'd9,   8, 16'h7E81, 1, 0);
    run_cmd(8'h0C, 8'h0D, 8'd2,   9, 16'h5555, 1, 0);
    run_cmd(8'hF0, 8'h0F, 8'd15,  1, 16'hFFFF, 1, 0);
    run_cmd(8'h11, 8'h22, 8'd16,  0, 16'h0000, 1, 0);
    // Overrun: three edges while the frame is transmitting
    run_cmd(8'h21, 8'h43, 8'd1,   2, 16'h9A0B, 1, 3);
    // Level hold of 2 and 20 cycles
    run_cmd(8'h31, 8'h32, 8'd4,   3, 16'h3132, 2, 0);
    run_cmd(8'h41, 8'h42, 8'd6,   5, 16'h4142, 20, 0);

    // Force 300 drops while TX is held busy
    base = cap.size(); s0 = alu_starts; hold_busy = 1'b1;
    tick();
    bus.i_num_1 = 8'h77; bus.i_num_2 = 8'h88; bus.i_opcode = 8'hFF;
    bus.i_cmd_done = 1'b1; hold_left = 1;
    budget = 0;
    while (bus.i_tx_busy !== 1'b1 && budget < 100) begin tick(); budget++; end
    check("hold_reached", 32'(bus.i_tx_busy), 32'd1);
    for (int i = 0; i < 300; i++) begin
      tick(); tick();
      bus.i_cmd_done = 1'b1; hold_left = 1;
      drop_exp = sat_inc(drop_exp);
    end
    tick(); tick();
    check("drop_saturated", 32'(bus.o_drop_count), 32'(drop_exp));
    check("drop_sat_value", 32'(bus.o_drop_count), 32'hFF);
    hold_busy = 1'b0;
    budget = 0;
    while (!(cap.size() == base + 3 && bus.o_busy === 1'b0) && budget < 200) begin
      tick(); budget++;
    end
    for (int i = 0; i < 3; i++) begin
      got = (cap.size() > base + i) ? cap[base + i] : 8'hxx;
      check($sformatf("held_byte%0d", i), 32'(got), (i == 0) ? 32'h02 : 32'h00);
    end
    check("held_no_alu", 32'(alu_starts - s0), 32'd0);

    // Async reset while waiting on TX of the second byte
    base = cap.size();
    tick();
    bus.i_num_1 = 8'hA5; bus.i_num_2 = 8'h5A; bus.i_opcode = 8'd7;
    bus.i_cmd_done = 1'b1; hold_left = 1;
    repeat (3) tick();
    bus.i_alu_done = 1'b1; bus.i_alu_result = 16'hC3D4;
    tick();
    bus.i_alu_done = 1'b0;
    budget = 0;
    while (!(cap.size() == base + 2 && bus.i_tx_busy === 1'b1) && budget < 200) begin
      tick(); budget++;
    end
    check("reach_second_byte", 32'(cap.size() - base), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.o_busy), 32'd0);
    check("arst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("arst_tx_start", 32'(bus.o_tx_start), 32'd0);
    check("arst_alu_start", 32'(bus.o_alu_start), 32'd0);
    check("arst_alu_a", 32'(bus.o_alu_a), 32'd0);
    check("arst_alu_b", 32'(bus.o_alu_b), 32'd0);
    check("arst_alu_op", 32'(bus.o_alu_op), 32'd0);
    check("arst_drop", 32'(bus.o_drop_count), 32'd0);
    drop_exp = 8'h00;
    s0 = alu_starts;
    repeat (3) tick();
    check("arst_no_more_bytes", 32'(cap.size() - base), 32'd2);
    check("arst_no_alu", 32'(alu_starts - s0), 32'd0);
    #1 rst_n = 1'b1;
    run_cmd(8'h13, 8'h57, 8'd11, 6, 16'h2468, 1, 0);

    // Random commands against the frame model
    for (int k = 0; k < 30; k++) begin
      logic [7:0]  ra, rb, rop;
      logic [15:0] rr;
      int          rd;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rr  = 16'($urandom);
      rop = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      rd  = $urandom_range(0, 11);
      run_cmd(ra, rb, rop, rd, rr, $urandom_range(1, 4), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/coproc_sequencer.md
Name: coproc_sequencer

Overview:
Command controller between the UART-side byte demultiplexer and the ALU/UART-TX path of the co-processor. It accepts one decoded command (two operands plus an opcode), validates the opcode, and launches the ALU with a start pulse. It waits for the ALU result, bounded by a timeout, then serialises a 3-byte response frame (status, result high, result low) to the UART transmitter over a start/busy handshake.

Parameters:
MAX_OPCODE, 8'd15, highest legal opcode; any larger opcode is rejected without starting the ALU.
TIMEOUT_CYCLES, 16'd1000, cycles spent in WAIT_ALU before the command is aborted (1..65535).

Ports:
i_clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
i_cmd_done  in  1  command-complete flag from the demux; may stay high for several cycles; only its rising edge is acted on.
i_num_1  in  8  operand A.
i_num_2  in  8  operand B.
i_opcode  in  8  operation code.
o_alu_a  out  8  latched operand A.
o_alu_b  out  8  latched operand B.
o_alu_op  out  8  latched opcode.
o_alu_start  out  1  one-cycle ALU launch pulse.
i_alu_done  in  1  ALU result valid; sampled in WAIT_ALU only.
i_alu_result  in  16  ALU result; captured in the cycle i_alu_done is high.
o_tx_data  out  8  byte presented to UART TX.
o_tx_start  out  1  one-cycle transmit request.
i_tx_busy  in  1  high while UART TX is shifting a byte.
o_busy  out  1  high in every state except IDLE.
o_drop_count  out  8  saturating count of commands dropped because the block was busy.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; the internal i_cmd_done delay register is cleared to 0; timeout counter 0.
- Reset asserted mid-operation aborts immediately. No further ALU or TX pulses are issued and no partial frame is resumed.
- All outputs are registered.
- Edge detect: cmd_edge = i_cmd_done & ~prev_done, where prev_done is i_cmd_done delayed by one cycle.
- IDLE:
  - On cmd_edge, latch i_num_1, i_num_2 and i_opcode into o_alu_a, o_alu_b and o_alu_op.
  - If opcode <= MAX_OPCODE, go to LAUNCH; otherwise set status=8'h02, result=16'h0000 and go to SEND.
- LAUNCH: o_alu_start=1 for exactly this one cycle; clear timeout counter; go to WAIT_ALU. Start is therefore high one cycle after the edge cycle.
- WAIT_ALU: the counter increments each cycle.
  - If i_alu_done=1, capture i_alu_result, set status=8'h00, go to SEND. i_alu_done has priority over the timeout in the same cycle.
  - Else if counter == TIMEOUT_CYCLES-1, set status=8'h01, result=16'h0000, go to SEND.
- Byte index idx runs 0,1,2 and selects status, result[15:8], result[7:0] in that order.
- SEND: when i_tx_busy=0, drive o_tx_data=byte[idx] and o_tx_start=1 for one cycle, then go to WAIT_ACK. While i_tx_busy=1, hold SEND with o_tx_start=0.
- WAIT_ACK: wait until i_tx_busy=1, then go to WAIT_TX. o_tx_data stays stable through WAIT_ACK and WAIT_TX.
- WAIT_TX: wait until i_tx_busy=0. If idx==2, go to IDLE; else idx+1 and go to SEND.
- Busy drop: a cmd_edge in any state other than IDLE is discarded.
  - o_drop_count increments and saturates at 8'hFF.
  - Latched operands are not disturbed.
  - An edge in the same cycle as the WAIT_TX->IDLE transition is dropped, because the state is not yet IDLE.
- A level held high on i_cmd_done never re-triggers; a new low->high transition is required.
- i_alu_done outside WAIT_ALU is ignored.
- o_busy = (state != IDLE).

Test Plan:
- Normal op: A=8'h12, B=8'h34, op=3; ALU returns 16'h0446 four cycles after start -> one o_alu_start pulse one cycle after the edge; TX bytes 00, 04, 46 in order; o_busy low after the third byte.
- Invalid opcode: op=8'h20 -> no o_alu_start; TX bytes 02, 00, 00.
- Timeout: TIMEOUT_CYCLES=8, ALU never responds -> exactly 8 cycles in WAIT_ALU; TX bytes 01, 00, 00. Repeat with i_alu_done in cycle 8 -> status 00 and the captured result.
- Overrun: send 3 command edges while the first frame is transmitting -> only the first frame is sent; o_drop_count=3. Then force 300 drops -> o_drop_count=8'hFF.
- Level hold: i_cmd_done held high for 2 cycles, then 20 cycles -> exactly one command each time; no drops counted.
- Async reset during WAIT_TX of byte 1 -> all outputs 0 with no clock edge needed; after release a new command produces a full, correct 3-byte frame.
